// File: rtl/ipm2l_hsstlp_fifo_clr_pkg.sv
// ----------------------------------------------------------------------------
// ipm2l_hsstlp_fifo_clr_pkg
// Shared definitions for the HSSTLP TX-FIFO clear controller:
//   - clr_state_t : per-group clear sequencer state encoding
//   - clog2max    : width of the shared settle/pulse counter
// ----------------------------------------------------------------------------
package ipm2l_hsstlp_fifo_clr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_DONE   = 2'd3
    } clr_state_t;

    // One counter serves both the settle and the pulse phases, so it must
    // hold the larger of the two terminal values. Never narrower than 1 bit.
    function automatic int clog2max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ipm2l_hsstlp_fifo_clr_grp.sv
// ----------------------------------------------------------------------------
// ipm2l_hsstlp_fifo_clr_grp
// Clear sequencer for one bonding group: CDR-align edge capture, per-lane
// lock, settle delay, multi-cycle FIFO clear pulse and completion pulse.
// Bypass groups register the user clear request instead.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   lane_srst     per-lane synchronous soft reset (active-high)
//   align_vld     per-lane CDR aligned, already masked by RX enable
//   rxlane_done   per-lane RX reset sequence complete
//   usr_fifo_clr  per-lane user clear request (bypass only)
//   fifo_clr_en   per-lane FIFO clear to PCS (registered)
//   clr_done      1-cycle pulse after a completed clear (registered)
//   busy          sequencer not idle (registered)
// ----------------------------------------------------------------------------
module ipm2l_hsstlp_fifo_clr_grp
    import ipm2l_hsstlp_fifo_clr_pkg::*;
#(
    parameter int GROUP_SIZE    = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int CLR_PULSE_LEN = 4,
    parameter bit BYPASS        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GROUP_SIZE-1:0] lane_srst,
    input  logic [GROUP_SIZE-1:0] align_vld,
    input  logic [GROUP_SIZE-1:0] rxlane_done,
    input  logic [GROUP_SIZE-1:0] usr_fifo_clr,
    output logic [GROUP_SIZE-1:0] fifo_clr_en,
    output logic                  clr_done,
    output logic                  busy
);

    // Single-lane groups have nothing to bond, so their sequencer stays idle.
    localparam bit FSM_EN = (!BYPASS) && (GROUP_SIZE > 1);
    localparam int CNT_W  = clog2max(SETTLE_CYCLES, CLR_PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(CLR_PULSE_LEN - 1);

    clr_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [GROUP_SIZE-1:0] vld_p1;
    logic [GROUP_SIZE-1:0] lock;
    logic [GROUP_SIZE-1:0] byp_q;
    logic                  clr_q;
    logic                  done_q;
    logic                  busy_q;

    logic [GROUP_SIZE-1:0] rise;
    logic                  any_srst;
    logic                  all_done;
    logic                  go;
    logic                  clr_entry;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rise     = align_vld & ~vld_p1;
    assign any_srst = |lane_srst;
    assign all_done = &rxlane_done;
    assign go       = (|lock) && all_done;

    // The edge on which the group enters CLEAR; it also consumes the locks,
    // so a rise landing on this same edge is deliberately dropped.
    always_comb begin
        clr_entry = 1'b0;
        if (FSM_EN && !any_srst) begin
            case (state)
                ST_IDLE:   clr_entry = go && (SETTLE_CYCLES == 0);
                ST_SETTLE: clr_entry = all_done && (cnt == SETTLE_LAST);
                default:   clr_entry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            lock   <= '0;
            byp_q  <= '0;
        end else begin
            vld_p1 <= align_vld;
            for (int i = 0; i < GROUP_SIZE; i++) begin
                if (lane_srst[i])
                    lock[i] <= 1'b0;
                else if (clr_entry)
                    lock[i] <= 1'b0;
                else if (rise[i])
                    lock[i] <= 1'b1;
            end
            byp_q <= BYPASS ? (usr_fifo_clr & ~lane_srst) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (!FSM_EN || any_srst) begin
            // Soft reset abandons any sequence in flight without a done pulse.
            state  <= ST_IDLE;
            cnt    <= '0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (clr_entry) begin
                        state  <= ST_CLEAR;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end else if (go) begin
                        state  <= ST_SETTLE;
                        busy_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // A lane dropping out restarts the settle; locks survive.
                    if (!all_done) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (clr_entry) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        clr_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_CLEAR: begin
                    if (cnt == PULSE_LAST) begin
                        state  <= ST_DONE;
                        cnt    <= '0;
                        clr_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_clr_en = BYPASS ? byp_q : {GROUP_SIZE{clr_q}};
    assign clr_done    = done_q;
    assign busy        = busy_q;

endmodule

// File: rtl/ipm2l_hsstlp_fifo_clr_ctrl.sv
// ----------------------------------------------------------------------------
// ipm2l_hsstlp_fifo_clr_ctrl
// TX-FIFO clear controller for HSSTLP lanes. One clear sequencer per bonding
// group; bypass groups pass the user clear request through a register.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   lane_srst     [NUM_LANES] per-lane synchronous soft reset
//   cdr_align     [NUM_LANES] CDR aligned per lane
//   rxlane_done   [NUM_LANES] RX lane reset sequence complete
//   usr_fifo_clr  [NUM_LANES] user clear request (bypass groups only)
//   fifo_clr_en   [NUM_LANES] FIFO clear to PCS
//   grp_clr_done  [NUM_GRP]   1-cycle pulse per completed clear
//   grp_busy      [NUM_GRP]   group sequencer not idle
// ----------------------------------------------------------------------------
module ipm2l_hsstlp_fifo_clr_ctrl
    import ipm2l_hsstlp_fifo_clr_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int GROUP_SIZE    = 2,
    parameter logic [NUM_LANES-1:0] RX_ENABLE = {NUM_LANES{1'b1}},
    parameter logic [NUM_LANES/GROUP_SIZE-1:0] BYPASS_BONDING = '0,
    parameter int SETTLE_CYCLES = 16,
    parameter int CLR_PULSE_LEN = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            lane_srst,
    input  logic [NUM_LANES-1:0]            cdr_align,
    input  logic [NUM_LANES-1:0]            rxlane_done,
    input  logic [NUM_LANES-1:0]            usr_fifo_clr,
    output logic [NUM_LANES-1:0]            fifo_clr_en,
    output logic [NUM_LANES/GROUP_SIZE-1:0] grp_clr_done,
    output logic [NUM_LANES/GROUP_SIZE-1:0] grp_busy
);

    localparam int NUM_GRP = NUM_LANES / GROUP_SIZE;

    logic [NUM_LANES-1:0] align_vld;

    // Disabled lanes can never start a sequence.
    assign align_vld = cdr_align & RX_ENABLE;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        ipm2l_hsstlp_fifo_clr_grp #(
            .GROUP_SIZE    (GROUP_SIZE),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .CLR_PULSE_LEN (CLR_PULSE_LEN),
            .BYPASS        (BYPASS_BONDING[g])
        ) u_grp (
            .clk          (clk),
            .rst_n        (rst_n),
            .lane_srst    (lane_srst[g*GROUP_SIZE +: GROUP_SIZE]),
            .align_vld    (align_vld[g*GROUP_SIZE +: GROUP_SIZE]),
            .rxlane_done  (rxlane_done[g*GROUP_SIZE +: GROUP_SIZE]),
            .usr_fifo_clr (usr_fifo_clr[g*GROUP_SIZE +: GROUP_SIZE]),
            .fifo_clr_en  (fifo_clr_en[g*GROUP_SIZE +: GROUP_SIZE]),
            .clr_done     (grp_clr_done[g]),
            .busy         (grp_busy[g])
        );
    end

endmodule

// File: tb/tb_ipm2l_hsstlp_fifo_clr_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ipm2l_hsstlp_fifo_clr_ctrl. Three configurations share stimulus:
//   A: 4 lanes, one group of 4, settle 4, pulse 2
//   B: 4 lanes, groups of 2, settle 3, pulse 3
//   C: 4 lanes, groups of 2, settle 0, pulse 1, group1 bypass, lane0 disabled
// The reference model tracks each group as "cycles since sequence start".
// ----------------------------------------------------------------------------
module tb_ipm2l_hsstlp_fifo_clr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] lane_srst = '0, cdr_align = '0, rxlane_done = 4'hF, usr_fifo_clr = '0;
    logic [3:0] clr_a, clr_b, clr_c;
    logic       done_a, busy_a;
    logic [1:0] done_b, busy_b, done_c, busy_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ipm2l_hsstlp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(4), .RX_ENABLE(4'hF),
        .BYPASS_BONDING(1'b0), .SETTLE_CYCLES(4), .CLR_PULSE_LEN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .lane_srst(lane_srst), .cdr_align(cdr_align),
        .rxlane_done(rxlane_done), .usr_fifo_clr(usr_fifo_clr),
        .fifo_clr_en(clr_a), .grp_clr_done(done_a), .grp_busy(busy_a));

    ipm2l_hsstlp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(2), .RX_ENABLE(4'hF),
        .BYPASS_BONDING(2'b00), .SETTLE_CYCLES(3), .CLR_PULSE_LEN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .lane_srst(lane_srst), .cdr_align(cdr_align),
        .rxlane_done(rxlane_done), .usr_fifo_clr(usr_fifo_clr),
        .fifo_clr_en(clr_b), .grp_clr_done(done_b), .grp_busy(busy_b));

    ipm2l_hsstlp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(2), .RX_ENABLE(4'b1110),
        .BYPASS_BONDING(2'b10), .SETTLE_CYCLES(0), .CLR_PULSE_LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .lane_srst(lane_srst), .cdr_align(cdr_align),
        .rxlane_done(rxlane_done), .usr_fifo_clr(usr_fifo_clr),
        .fifo_clr_en(clr_c), .grp_clr_done(done_c), .grp_busy(busy_c));

    // ---------------- reference model ----------------
    int         c_gs   [3] = '{4, 2, 2};
    int         c_s    [3] = '{4, 3, 0};
    int         c_p    [3] = '{2, 3, 1};
    logic [1:0] c_byp  [3] = '{2'b00, 2'b00, 2'b10};
    logic [3:0] c_rxen [3] = '{4'hF, 4'hF, 4'b1110};

    int         age   [3][2];   // -1 idle, else cycles since the sequence began
    logic [3:0] lock  [3];
    logic [3:0] prev  [3];
    logic [3:0] byp_q [3];

    int   m_lo, m_old, m_new;
    logic m_any_lock, m_all_done, m_any_srst, m_entry, m_pos, m_vld;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            age[i][0] = -1; age[i][1] = -1;
            lock[i] = '0; prev[i] = '0; byp_q[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 4 / c_gs[i]; g++) begin
                m_lo = g * c_gs[i];
                m_any_lock = 1'b0; m_all_done = 1'b1; m_any_srst = 1'b0;
                for (int l = m_lo; l < m_lo + c_gs[i]; l++) begin
                    m_any_lock = m_any_lock | lock[i][l];
                    m_all_done = m_all_done & rxlane_done[l];
                    m_any_srst = m_any_srst | lane_srst[l];
                end
                m_old = age[i][g];
                if (c_byp[i][g] || c_gs[i] == 1 || m_any_srst) m_new = -1;
                else if (m_old < 0) m_new = (m_any_lock && m_all_done) ? 0 : -1;
                else if (m_old < c_s[i] && !m_all_done) m_new = -1;
                else if (m_old == c_s[i] + c_p[i]) m_new = -1;
                else m_new = m_old + 1;
                m_entry = (m_new == c_s[i]) && (m_old != c_s[i]);
                for (int l = m_lo; l < m_lo + c_gs[i]; l++) begin
                    m_vld = cdr_align[l] & c_rxen[i][l];
                    m_pos = m_vld & ~prev[i][l];
                    prev[i][l] = m_vld;
                    if (lane_srst[l]) lock[i][l] = 1'b0;
                    else if (m_entry) lock[i][l] = 1'b0;
                    else if (m_pos) lock[i][l] = 1'b1;
                    byp_q[i][l] = c_byp[i][g] & usr_fifo_clr[l] & ~lane_srst[l];
                end
                age[i][g] = m_new;
            end
        end
    endtask

    // {clr[3:0], done[1:0], busy[1:0]}
    function automatic logic [7:0] expv(input int i);
        logic [3:0] e_clr;
        logic [1:0] e_done, e_busy;
        int g, a;
        e_clr = '0; e_done = '0; e_busy = '0;
        for (int l = 0; l < 4; l++) begin
            g = l / c_gs[i];
            a = age[i][g];
            if (c_byp[i][g]) e_clr[l] = byp_q[i][l];
            else e_clr[l] = (c_gs[i] > 1) && (a >= c_s[i]) && (a < c_s[i] + c_p[i]);
        end
        for (int gg = 0; gg < 4 / c_gs[i]; gg++) begin
            e_done[gg] = (age[i][gg] == c_s[i] + c_p[i]);
            e_busy[gg] = (age[i][gg] >= 0);
        end
        return {e_clr, e_done, e_busy};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("model_a", {clr_a, 1'b0, done_a, 1'b0, busy_a}, expv(0));
                chk("model_b", {clr_b, done_b, busy_b}, expv(1));
                chk("model_c", {clr_c, done_c, busy_c}, expv(2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) step();
        chk("rst_a", {clr_a, 1'b0, done_a, 1'b0, busy_a}, 8'h00);
        chk("rst_b", {clr_b, done_b, busy_b}, 8'h00);
        chk("rst_c", {clr_c, done_c, busy_c}, 8'h00);
        rst_n = 1'b1;
        repeat (2) step();

        // Settle and clear timing on A: rise sampled at edge k
        cdr_align = 4'b0100;
        step();
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("t1_pre", 8'(clr_a), 8'h00);
        end
        step(); chk("t1_clr_k5", 8'(clr_a), 8'h0F); chk("t1_busy", 8'(busy_a), 8'h01);
        step(); chk("t1_clr_k6", 8'(clr_a), 8'h0F);
        step(); chk("t1_fall", 8'(clr_a), 8'h00); chk("t1_done", 8'(done_a), 8'h01);
        step(); chk("t1_idle", {6'd0, done_a, busy_a}, 8'h00);

        // Independent groups on B
        rxlane_done = 4'b0111;
        cdr_align   = 4'b0101;
        step();
        repeat (3) step();
        step(); chk("t2_g0_clr", 8'(clr_b), 8'h03);
        repeat (4) step();
        cdr_align = 4'b1101;
        step();
        cdr_align = 4'b0101;
        repeat (5) step();
        chk("t2_g1_hold", {4'd0, clr_b[3:2], 1'b0, busy_b[1]}, 8'h00);
        rxlane_done = 4'hF;
        step(); chk("t2_g1_busy", 8'(busy_b[1]), 8'h01);
        step(); step(); chk("t2_g1_pre", 8'(clr_b[3:2]), 8'h00);
        step(); chk("t2_g1_clr", 8'(clr_b), 8'h0C);
        repeat (6) step();

        // Settle abort on A, lock retained
        cdr_align = 4'b0000;
        repeat (2) step();
        cdr_align = 4'b0001;
        step();
        repeat (3) step();
        rxlane_done = 4'b1101;
        step(); chk("t3_abort", {clr_a, 3'd0, busy_a}, 8'h00);
        rxlane_done = 4'hF;
        step(); chk("t3_rearm", 8'(busy_a), 8'h01);
        repeat (2) step();
        step(); chk("t3_pre", 8'(clr_a), 8'h00);
        step(); chk("t3_clr", 8'(clr_a), 8'h0F);
        repeat (6) step();

        // Soft reset during CLEAR cycle 1 of B group0
        cdr_align = 4'b0000;
        step();
        cdr_align = 4'b0001;
        step();
        repeat (3) step();
        step(); chk("t4_clr0", 8'(clr_b[1:0]), 8'h03);
        step();
        lane_srst = 4'b0010;
        step(); chk("t4_srst_clr", 8'(clr_b[1:0]), 8'h00);
        lane_srst = 4'b0000;
        step(); chk("t4_no_done", {6'd0, done_b[0], busy_b[0]}, 8'h00);
        step(); chk("t4_no_done2", 8'(done_b[0]), 8'h00);
        repeat (6) step();

        // Bypass group on C
        usr_fifo_clr = 4'b1000;
        chk("t5_delay", 8'(clr_c[3:2]), 8'h00);
        for (int e = 0; e < 3; e++) begin
            step();
            chk("t5_pass", {4'd0, clr_c[3:2], 1'b0, busy_c[1]}, 8'h08);
        end
        usr_fifo_clr = 4'b0000;
        step(); chk("t5_fall", 8'(clr_c[3:2]), 8'h00);

        // Re-trigger during CLEAR on A
        cdr_align = 4'b0000;
        repeat (2) step();
        cdr_align = 4'b0010;
        step();
        repeat (4) step();
        step(); chk("t6_first", 8'(clr_a), 8'h0F);
        cdr_align = 4'b1010;
        step();
        step(); chk("t6_done", 8'(done_a), 8'h01);
        step();
        step(); chk("t6_restart", 8'(busy_a), 8'h01);
        repeat (3) step();
        step(); chk("t6_second", 8'(clr_a), 8'h0F);
        repeat (6) step();

        // Masked lane 0 on C never triggers group0
        for (int e = 0; e < 16; e++) begin
            cdr_align[0] = ~cdr_align[0];
            step();
            chk("t6_mask", {4'd0, clr_c[1:0], 1'b0, busy_c[0]}, 8'h00);
        end

        // Asynchronous reset mid-SETTLE on A
        cdr_align = 4'b0000;
        repeat (8) step();
        cdr_align = 4'b0100;
        step();
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_a", {clr_a, 1'b0, done_a, 1'b0, busy_a}, 8'h00);
        chk("t6_async_b", {clr_b, done_b, busy_b}, 8'h00);
        #2 rst_n = 1'b1;
        repeat (2) step();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 7) == 0) cdr_align[l] = ~cdr_align[l];
                rxlane_done[l] = ($urandom_range(0, 15) != 0);
                lane_srst[l]   = ($urandom_range(0, 127) == 0);
            end
            usr_fifo_clr = 4'($urandom_range(0, 15));
            step();
        end
        lane_srst = '0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
